sw_alloc7: RTL and testbench
============================

SW_ALLOC7 -- requirements
Module: sw_alloc7

Interface
REQ-001 The block SHALL have parameter NPORT, default 7, giving the number of input and output ports; only 7 is supported.
REQ-002 The block SHALL have parameter PW, default 3, giving the port-index width; code 0 means "none".
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-low.
REQ-005 Ports req1..req7  input  1 each  input i holds a flit at its buffer head.
REQ-006 Ports targ1..targ7  input  3 each  output port requested by input i (1..7; 0 = none).
REQ-007 Ports tail1..tail7  input  1 each  head flit of input i is a packet tail.
REQ-008 Ports alloc1..alloc7  input  1 each  output j has downstream buffer space this cycle (from the VC allocator).
REQ-009 Ports gnt1..gnt7  output  1 each  registered grant to input i; pops one flit.
REQ-010 Ports sel1..sel7  output  3 each  registered crossbar select for output j: winning input index 1..7, or 0 = idle.

Function
REQ-011 Each output j SHALL run an independent 2-state FSM: FREE and LOCKED (owner register, 3 bits).
REQ-012 Input i requests output j when req_i=1 and targ_i==j; targ values of 0 are never a request.
REQ-013 In FREE, with alloc_j=1 and at least one request, output j SHALL pick one winner by round-robin, starting from its priority pointer ptr_j.
REQ-014 Winner selection SHALL search ptr_j, ptr_j+1, ... 7, 1, ... ptr_j-1. The first requester in that order wins.
REQ-015 On a grant to input k, ptr_j SHALL become k+1, wrapping 7 to 1. With no grant, ptr_j SHALL hold.
REQ-016 On a FREE grant with tail_k=0, the FSM SHALL move to LOCKED with owner=k. With tail_k=1 (single-flit packet), it SHALL stay FREE.
REQ-017 In LOCKED, only the owner may be granted: a grant requires req_owner=1, targ_owner==j and alloc_j=1. Other requesters are ignored.
REQ-018 A LOCKED grant with tail_owner=1 SHALL return the FSM to FREE on the same edge. Otherwise it stays LOCKED.
REQ-019 If the owner drops req, the FSM SHALL stay LOCKED with no grant and sel_j=0 until the owner resumes.
REQ-020 alloc_j=0 SHALL suppress any grant on output j in both states; state and pointer hold.
REQ-021 Latency: request sampled at edge N SHALL produce gnt_k=1 and sel_j=k in the cycle after edge N. The outputs are registered, one cycle wide per granted flit.
REQ-022 gnt_i SHALL be the OR over all outputs of "output grants i". Because each input targets one output, at most one output can grant input i.
REQ-023 Up to 7 grants SHALL be issued per cycle, one per output. Different outputs grant different inputs in parallel.
REQ-024 Back-to-back grants to the same input on consecutive cycles SHALL be allowed.

Reset
REQ-025 While rst=0 at a rising edge: all FSMs SHALL go to FREE, owners to 0, ptr_j to 1, gnt1..7 to 0, sel1..7 to 0.
REQ-026 Reset asserted mid-packet SHALL drop any lock. Recovery of the partial packet is the upstream buffer's job.
REQ-027 There SHALL be no asynchronous reset path.

Structure
REQ-028 A shared package SHALL hold NPORT, PW, the NONE=0 port code, and the FSM state encoding FREE/LOCKED.
REQ-029 One sub-module, rr_arb7, SHALL implement the 7-way round-robin pick (request vector and pointer in; one-hot winner and index out). It is combinational, and sw_alloc7 instantiates it 7 times.
REQ-030 The pointer, FSM and owner registers SHALL live in sw_alloc7, one per output.

Verification
REQ-031 Contention: req1..3=1, targ1..3=4, tail=1, alloc4=1 held for 3 cycles from reset. Required sel4 sequence is 1,2,3 and gnt1, gnt2, gnt3 each pulse once, in order.
REQ-032 Lock: input 2 sends a 3-flit packet to output 5 (tail on flit 3) while input 6 also requests 5. Required sel5 = 2,2,2,6, and gnt6 stays 0 until after input 2's tail.
REQ-033 Backpressure: the owner is locked on output 3 and alloc3 drops for 2 cycles. Required gnt=0 and sel3=0 for those cycles, then the grant resumes with the owner still the same input.
REQ-034 Parallel: inputs 1..7 target outputs 7..1, all alloc=1. Required all gnt1..7=1 in the same cycle, with sel_j = 8-j.
REQ-035 Wrap/reset: ptr7 reaches 1 after input 7 is granted. Then rst=0 is applied mid-packet on output 7. Required next cycle: all gnt=0, all sel=0. Afterwards, a fresh request from input 4 to output 7 is granted with no lock carried over.

Source files
------------

// File: rtl/sw_alloc7_pkg.sv
// Shared definitions for the 7-port switch allocator.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package sw_alloc7_pkg;

    localparam int NPORT = 7;
    localparam int PW    = 3;

    // Port code meaning "no port / idle".
    localparam logic [PW-1:0] NONE = '0;

    // Per-output packet lock state.
    typedef enum logic {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/sw_alloc7_rr_arb7.sv
// 7-way round-robin pick starting at a priority pointer.
// Latency: combinational.
// Backpressure: none; the caller decides whether the pick is used.
// Ports:
//   req_i      request vector, bit n = input n+1
//   ptr_i      highest-priority input index (1..7)
//   win_oh_o   one-hot winner, bit n = input n+1
//   win_idx_o  winner index 1..7, or NONE when no request
module rr_arb7
    import sw_alloc7_pkg::*;
(
    input  logic [NPORT-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [NPORT-1:0] win_oh_o,
    output logic [PW-1:0]    win_idx_o
);

    logic          found;
    logic [PW-1:0] base;
    logic [PW-1:0] cand;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = NONE;
        found     = 1'b0;
        cand      = '0;
        // A pointer of 0 never occurs in normal use; treat it as input 1.
        base      = (ptr_i == NONE) ? '0 : ptr_i - PW'(1);
        for (int n = 0; n < NPORT; n++) begin
            cand = PW'((int'(base) + n) % NPORT);
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                win_oh_o[cand]  = 1'b1;
                win_idx_o       = cand + PW'(1);
            end
        end
    end

endmodule

// File: rtl/sw_alloc7.sv
// 7x7 switch allocator with per-output round-robin and wormhole packet lock.
// Latency: request sampled at a rising edge yields registered gnt/sel right after it.
// Backpressure: alloc_j=0 suppresses any grant on output j; state and pointer hold.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   req1..7, targ1..7, tail1..7  per-input head flit valid, target output, tail flag
//   alloc1..7                 per-output downstream space
//   gnt1..7                   per-input registered grant (pops one flit)
//   sel1..7                   per-output registered crossbar select (0 = idle)
module sw_alloc7
    import sw_alloc7_pkg::state_e;
    import sw_alloc7_pkg::ST_FREE;
    import sw_alloc7_pkg::ST_LOCKED;
#(
    parameter int NPORT = 7,
    parameter int PW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req1, req2, req3, req4, req5, req6, req7,
    input  logic [PW-1:0] targ1, targ2, targ3, targ4, targ5, targ6, targ7,
    input  logic          tail1, tail2, tail3, tail4, tail5, tail6, tail7,
    input  logic          alloc1, alloc2, alloc3, alloc4, alloc5, alloc6, alloc7,
    output logic          gnt1, gnt2, gnt3, gnt4, gnt5, gnt6, gnt7,
    output logic [PW-1:0] sel1, sel2, sel3, sel4, sel5, sel6, sel7
);

    localparam logic [PW-1:0] NONE_C = '0;

    logic [NPORT-1:0] req_v, tail_v, alloc_v;
    logic [PW-1:0]    targ_v [NPORT];

    assign req_v   = {req7, req6, req5, req4, req3, req2, req1};
    assign tail_v  = {tail7, tail6, tail5, tail4, tail3, tail2, tail1};
    assign alloc_v = {alloc7, alloc6, alloc5, alloc4, alloc3, alloc2, alloc1};
    assign targ_v[0] = targ1;
    assign targ_v[1] = targ2;
    assign targ_v[2] = targ3;
    assign targ_v[3] = targ4;
    assign targ_v[4] = targ5;
    assign targ_v[5] = targ6;
    assign targ_v[6] = targ7;

    // Per-output state
    state_e        state_q [NPORT];
    state_e        state_d [NPORT];
    logic [PW-1:0] owner_q [NPORT];
    logic [PW-1:0] owner_d [NPORT];
    logic [PW-1:0] ptr_q   [NPORT];
    logic [PW-1:0] ptr_d   [NPORT];
    logic [PW-1:0] sel_q   [NPORT];
    logic [PW-1:0] sel_d   [NPORT];
    logic [NPORT-1:0] gnt_q, gnt_d;

    // Request matrix row j: which inputs want output j+1.
    logic [NPORT-1:0] req_mat [NPORT];
    logic [NPORT-1:0] arb_oh  [NPORT];
    logic [PW-1:0]    arb_idx [NPORT];
    logic [PW-1:0]    win     [NPORT];

    for (genvar j = 0; j < NPORT; j++) begin : g_out
        for (genvar i = 0; i < NPORT; i++) begin : g_in
            assign req_mat[j][i] = req_v[i] && (targ_v[i] == PW'(j + 1));
        end

        rr_arb7 u_arb (
            .req_i     (req_mat[j]),
            .ptr_i     (ptr_q[j]),
            .win_oh_o  (arb_oh[j]),
            .win_idx_o (arb_idx[j])
        );
    end

    always_comb begin
        gnt_d = '0;
        for (int j = 0; j < NPORT; j++) begin
            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            ptr_d[j]   = ptr_q[j];
            sel_d[j]   = NONE_C;
            win[j]     = NONE_C;

            if (alloc_v[j]) begin
                if (state_q[j] == ST_LOCKED) begin
                    // Only the owner may continue; everyone else waits for its tail.
                    if (owner_q[j] != NONE_C && req_mat[j][owner_q[j] - PW'(1)]) begin
                        win[j] = owner_q[j];
                        if (tail_v[owner_q[j] - PW'(1)]) begin
                            state_d[j] = ST_FREE;
                            owner_d[j] = NONE_C;
                        end
                    end
                end else if (arb_idx[j] != NONE_C) begin
                    win[j] = arb_idx[j];
                    // Multi-flit packet: hold the output until the tail passes.
                    if (!(|(arb_oh[j] & tail_v))) begin
                        state_d[j] = ST_LOCKED;
                        owner_d[j] = arb_idx[j];
                    end
                end
            end

            if (win[j] != NONE_C) begin
                sel_d[j]              = win[j];
                gnt_d[win[j] - PW'(1)] = 1'b1;
                ptr_d[j]              = (win[j] == PW'(NPORT)) ? PW'(1) : win[j] + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_q <= '0;
            for (int j = 0; j < NPORT; j++) begin
                state_q[j] <= ST_FREE;
                owner_q[j] <= NONE_C;
                ptr_q[j]   <= PW'(1);
                sel_q[j]   <= NONE_C;
            end
        end else begin
            gnt_q <= gnt_d;
            for (int j = 0; j < NPORT; j++) begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                ptr_q[j]   <= ptr_d[j];
                sel_q[j]   <= sel_d[j];
            end
        end
    end

    assign {gnt7, gnt6, gnt5, gnt4, gnt3, gnt2, gnt1} = gnt_q;
    assign sel1 = sel_q[0];
    assign sel2 = sel_q[1];
    assign sel3 = sel_q[2];
    assign sel4 = sel_q[3];
    assign sel5 = sel_q[4];
    assign sel6 = sel_q[5];
    assign sel7 = sel_q[6];

endmodule

// File: tb/tb_sw_alloc7.sv
// Directed bench for sw_alloc7 with a per-cycle reference model.
// Latency: model predicts outputs one edge after inputs are applied.
// Backpressure: exercised through alloc inputs.
module tb_sw_alloc7;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:1] req, tail, alloc, gnt;
    logic [2:0] targ [1:7];
    logic [2:0] sel  [1:7];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sw_alloc7 dut (
        .clk(clk), .rst(rst),
        .req1(req[1]), .req2(req[2]), .req3(req[3]), .req4(req[4]),
        .req5(req[5]), .req6(req[6]), .req7(req[7]),
        .targ1(targ[1]), .targ2(targ[2]), .targ3(targ[3]), .targ4(targ[4]),
        .targ5(targ[5]), .targ6(targ[6]), .targ7(targ[7]),
        .tail1(tail[1]), .tail2(tail[2]), .tail3(tail[3]), .tail4(tail[4]),
        .tail5(tail[5]), .tail6(tail[6]), .tail7(tail[7]),
        .alloc1(alloc[1]), .alloc2(alloc[2]), .alloc3(alloc[3]), .alloc4(alloc[4]),
        .alloc5(alloc[5]), .alloc6(alloc[6]), .alloc7(alloc[7]),
        .gnt1(gnt[1]), .gnt2(gnt[2]), .gnt3(gnt[3]), .gnt4(gnt[4]),
        .gnt5(gnt[5]), .gnt6(gnt[6]), .gnt7(gnt[7]),
        .sel1(sel[1]), .sel2(sel[2]), .sel3(sel[3]), .sel4(sel[4]),
        .sel5(sel[5]), .sel6(sel[6]), .sel7(sel[7])
    );

    // ---------------- reference model ----------------
    // Per output: locked flag, owning input, next-priority input.
    bit   m_lock [1:7];
    int   m_own  [1:7];
    int   m_ptr  [1:7];
    bit [7:1] e_gnt = '0;
    int   e_sel  [1:7] = '{default: 0};
    bit   cmp_en = 1'b0;

    always @(posedge clk) begin
        e_gnt = '0;
        for (int j = 1; j <= 7; j++) e_sel[j] = 0;
        if (!rst) begin
            for (int j = 1; j <= 7; j++) begin
                m_lock[j] = 0; m_own[j] = 0; m_ptr[j] = 1;
            end
        end else begin
            for (int j = 1; j <= 7; j++) begin
                int k;
                k = 0;
                if (alloc[j]) begin
                    if (m_lock[j]) begin
                        if (req[m_own[j]] && targ[m_own[j]] == j) k = m_own[j];
                    end else begin
                        for (int n = 0; n < 7; n++) begin
                            int c;
                            c = (m_ptr[j] - 1 + n) % 7 + 1;
                            if (k == 0 && req[c] && targ[c] == j) k = c;
                        end
                    end
                end
                if (k != 0) begin
                    e_sel[j] = k;
                    e_gnt[k] = 1'b1;
                    m_ptr[j] = k % 7 + 1;
                    if (m_lock[j]) begin
                        if (tail[k]) begin m_lock[j] = 0; m_own[j] = 0; end
                    end else if (!tail[k]) begin
                        m_lock[j] = 1; m_own[j] = k;
                    end
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 1; i <= 7; i++) begin
                checks++;
                if (gnt[i] !== e_gnt[i]) begin
                    errors++;
                    $display("FAIL model_gnt%0d: got %b, expected %b at %0t", i, gnt[i], e_gnt[i], $time);
                end
                checks++;
                if (sel[i] !== 3'(e_sel[i])) begin
                    errors++;
                    $display("FAIL model_sel%0d: got %0d, expected %0d at %0t", i, sel[i], e_sel[i], $time);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr();
        req = '0; tail = '0; alloc = '0;
        for (int i = 1; i <= 7; i++) targ[i] = 3'd0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        clr();
        step(); step();
        cmp_en = 1'b1;
        chk("reset_gnt", {1'b0, gnt}, 8'd0);
        chk("reset_sel4", {5'd0, sel[4]}, 8'd0);
        rst = 1'b1;

        // Contention on output 4 with single-flit packets.
        for (int i = 1; i <= 3; i++) begin req[i] = 1; targ[i] = 3'd4; tail[i] = 1; end
        alloc[4] = 1;
        step(); chk("cont_sel4_a", {5'd0, sel[4]}, 8'd1); chk("cont_gnt_a", {1'b0, gnt}, 8'b0000_0001);
        step(); chk("cont_sel4_b", {5'd0, sel[4]}, 8'd2); chk("cont_gnt_b", {1'b0, gnt}, 8'b0000_0010);
        step(); chk("cont_sel4_c", {5'd0, sel[4]}, 8'd3); chk("cont_gnt_c", {1'b0, gnt}, 8'b0000_0100);
        clr();

        // Lock: 3-flit packet from input 2 holds output 5 against input 6.
        req[2] = 1; targ[2] = 3'd5; tail[2] = 0;
        req[6] = 1; targ[6] = 3'd5; tail[6] = 1;
        alloc[5] = 1;
        step(); chk("lock_sel5_1", {5'd0, sel[5]}, 8'd2); chk("lock_gnt6_1", {7'd0, gnt[6]}, 8'd0);
        step(); chk("lock_sel5_2", {5'd0, sel[5]}, 8'd2); chk("lock_gnt6_2", {7'd0, gnt[6]}, 8'd0);
        tail[2] = 1;
        step(); chk("lock_sel5_3", {5'd0, sel[5]}, 8'd2); chk("lock_gnt6_3", {7'd0, gnt[6]}, 8'd0);
        req[2] = 0;
        step(); chk("lock_sel5_4", {5'd0, sel[5]}, 8'd6); chk("lock_gnt6_4", {7'd0, gnt[6]}, 8'd1);
        clr();

        // Backpressure while input 1 owns output 3; input 5 contends.
        req[1] = 1; targ[1] = 3'd3; tail[1] = 0;
        req[5] = 1; targ[5] = 3'd3; tail[5] = 1;
        alloc[3] = 1;
        step(); chk("bp_sel3_0", {5'd0, sel[3]}, 8'd1);
        alloc[3] = 0;
        step(); chk("bp_sel3_1", {5'd0, sel[3]}, 8'd0); chk("bp_gnt_1", {1'b0, gnt}, 8'd0);
        step(); chk("bp_sel3_2", {5'd0, sel[3]}, 8'd0); chk("bp_gnt_2", {1'b0, gnt}, 8'd0);
        alloc[3] = 1;
        step(); chk("bp_sel3_3", {5'd0, sel[3]}, 8'd1); chk("bp_gnt_3", {1'b0, gnt}, 8'b0000_0001);
        tail[1] = 1;
        step(); chk("bp_sel3_4", {5'd0, sel[3]}, 8'd1);
        req[1] = 0;
        step(); chk("bp_sel3_5", {5'd0, sel[3]}, 8'd5);
        clr();

        // Parallel: input i -> output 8-i, all outputs open.
        for (int i = 1; i <= 7; i++) begin req[i] = 1; targ[i] = 3'(8 - i); tail[i] = 1; end
        alloc = '1;
        step();
        chk("par_gnt", {1'b0, gnt}, 8'h7f);
        for (int j = 1; j <= 7; j++) chk($sformatf("par_sel%0d", j), {5'd0, sel[j]}, 8'(8 - j));
        clr();

        // Wrap: ptr7 is 2 here; granting input 7 wraps it to 1.
        req[7] = 1; targ[7] = 3'd7; tail[7] = 1; alloc[7] = 1;
        step(); chk("wrap_sel7_a", {5'd0, sel[7]}, 8'd7);
        req[7] = 0;
        req[1] = 1; targ[1] = 3'd7; tail[1] = 0;
        req[5] = 1; targ[5] = 3'd7; tail[5] = 1;
        step(); chk("wrap_sel7_b", {5'd0, sel[7]}, 8'd1);
        // Reset mid-packet on output 7.
        rst = 1'b0;
        step();
        chk("rst_gnt", {1'b0, gnt}, 8'd0);
        for (int j = 1; j <= 7; j++) chk($sformatf("rst_sel%0d", j), {5'd0, sel[j]}, 8'd0);
        rst = 1'b1;
        clr();
        req[4] = 1; targ[4] = 3'd7; tail[4] = 1; alloc[7] = 1;
        step(); chk("post_sel7_a", {5'd0, sel[7]}, 8'd4); chk("post_gnt_a", {1'b0, gnt}, 8'b0000_1000);
        step(); chk("post_sel7_b", {5'd0, sel[7]}, 8'd4); chk("post_gnt_b", {1'b0, gnt}, 8'b0000_1000);
        clr();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
